dmem_port: RTL and testbench

DMEM_PORT -- requirements
Module: dmem_port

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_wrbuf.sv | 49 ++++
 rtl/dmem_port.sv | 155 +++++++++++++++
 tb/tb_dmem_port.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port.
//   state_t     : load sequencer state encoding
//   BE_WORD     : byte-enable mask for a full word access
//   TIMEOUT_DEF : default LD_WAIT limit in cycles
//   CNT_W       : width of the LD_WAIT timeout counter
//   byte_be()   : one-hot byte enable for a byte lane
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_REQ  = 2'd1,
    LD_WAIT = 2'd2,
    LD_DONE = 2'd3
  } state_t;

  localparam logic [3:0] BE_WORD     = 4'hF;
  localparam int         TIMEOUT_DEF = 255;
  localparam int         CNT_W       = 10;

  function automatic logic [3:0] byte_be(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/dmem_wrbuf.sv
// Single-entry posted write buffer.
//   clk, reset            : clock, async active-low reset
//   capture               : load addr/wdata/be into the entry (sets full)
//   hold                  : block draining this cycle (bus owned by a load)
//   ready                 : bus ReqReady
//   addr, wdata, be       : store payload to capture
//   full                  : entry holds a pending store
//   drain                 : store handshake on the bus this cycle
//   buf_addr/wdata/be     : pending store payload
module dmem_wrbuf
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        hold,
  input  logic        ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        full,
  output logic        drain,
  output logic [31:0] buf_addr,
  output logic [31:0] buf_wdata,
  output logic [3:0]  buf_be
);

  assign drain = full & ~hold & ready;

  // Capture wins over drain so a store can refill the entry in its drain cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full      <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      buf_be    <= '0;
    end else begin
      if (capture) begin
        full      <= 1'b1;
        buf_addr  <= addr;
        buf_wdata <= wdata;
        buf_be    <= be;
      end else if (drain) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dmem_port.sv
// Data-memory port: sequences loads over a request/response bus and posts
// stores through a single-entry write buffer.
//   clk, reset                       : clock, async active-low reset
//   MemReadM, MemWriteM, ByteM       : M-stage access type
//   ALUOutM, WriteDataM              : byte address, store data
//   ReadDataM                        : load result (held outside LD_DONE)
//   StallM                           : pipeline stall request
//   DataAbortM                       : one-cycle load abort
//   ReqValid/ReqReady/ReqWrite/ReqAddr/ReqWData/ReqBE : bus request
//   RspValid/RspData/RspErr          : bus read response
module dmem_port
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        ByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        DataAbortM,
  output logic        ReqValid,
  input  logic        ReqReady,
  output logic        ReqWrite,
  output logic [31:0] ReqAddr,
  output logic [31:0] ReqWData,
  output logic [3:0]  ReqBE,
  input  logic        RspValid,
  input  logic [31:0] RspData,
  input  logic        RspErr
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [31:0]      ld_addr;
  logic             ld_byte;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rd_data;
  logic             ld_err;
  logic [31:0]      rsp_fmt;
  logic [7:0]       rsp_byte;

  logic        wb_full, wb_drain, wb_capture;
  logic [31:0] wb_addr, wb_wdata;
  logic [3:0]  wb_be;

  logic ld_start, wait_done;

  // Loads wait for an empty buffer so the store reaches memory first.
  assign ld_start   = (state == IDLE) & MemReadM & ~wb_full;
  // A simultaneous load takes priority and the store is dropped.
  assign wb_capture = (state == IDLE) & MemWriteM & ~MemReadM & (~wb_full | wb_drain);
  assign wait_done  = (state == LD_WAIT) & (RspValid | (cnt == TO_LAST));

  dmem_wrbuf u_wrbuf (
    .clk       (clk),
    .reset     (reset),
    .capture   (wb_capture),
    .hold      (state == LD_REQ),
    .ready     (ReqReady),
    .addr      ({ALUOutM[31:2], 2'b00}),
    .wdata     (ByteM ? {4{WriteDataM[7:0]}} : WriteDataM),
    .be        (ByteM ? byte_be(ALUOutM[1:0]) : BE_WORD),
    .full      (wb_full),
    .drain     (wb_drain),
    .buf_addr  (wb_addr),
    .buf_wdata (wb_wdata),
    .buf_be    (wb_be)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_start) state_nxt = LD_REQ;
      LD_REQ:  if (ReqReady) state_nxt = LD_WAIT;
      LD_WAIT: if (wait_done) state_nxt = LD_DONE;
      LD_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_byte = RspData[7:0];
    case (ld_addr[1:0])
      2'd0: rsp_byte = RspData[7:0];
      2'd1: rsp_byte = RspData[15:8];
      2'd2: rsp_byte = RspData[23:16];
      2'd3: rsp_byte = RspData[31:24];
      default: rsp_byte = RspData[7:0];
    endcase
    rsp_fmt = ld_byte ? {24'h0, rsp_byte} : RspData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_addr <= '0;
      ld_byte <= 1'b0;
      cnt     <= '0;
      rd_data <= '0;
      ld_err  <= 1'b0;
    end else begin
      if (ld_start) begin
        ld_addr <= ALUOutM;
        ld_byte <= ByteM;
      end
      cnt <= (state == LD_WAIT) ? cnt + 1'b1 : '0;
      // A response in the final timeout cycle still counts as a response.
      if (wait_done) begin
        if (RspValid && !RspErr) begin
          rd_data <= rsp_fmt;
          ld_err  <= 1'b0;
        end else begin
          rd_data <= '0;
          ld_err  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    ReqValid = 1'b0;
    ReqWrite = 1'b0;
    ReqAddr  = '0;
    ReqWData = '0;
    ReqBE    = '0;
    if (state == LD_REQ) begin
      ReqValid = 1'b1;
      ReqAddr  = {ld_addr[31:2], 2'b00};
      ReqBE    = BE_WORD;
    end else if (wb_full) begin
      ReqValid = 1'b1;
      ReqWrite = 1'b1;
      ReqAddr  = wb_addr;
      ReqWData = wb_wdata;
      ReqBE    = wb_be;
    end
  end

  // Gated by reset so the stall drops immediately on reset assertion.
  assign StallM = reset & (((state == IDLE) & MemReadM) | (state == LD_REQ) |
                           (state == LD_WAIT) | (MemWriteM & wb_full & ~wb_drain));
  assign DataAbortM = (state == LD_DONE) & ld_err;
  assign ReadDataM  = rd_data;

endmodule

// File: tb/tb_dmem_port.sv
module tb_dmem_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0, ByteM = 1'b0;
  logic [31:0] ALUOutM = '0, WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        StallM, DataAbortM;
  logic        ReqValid, ReqWrite;
  logic        ReqReady = 1'b0;
  logic [31:0] ReqAddr, ReqWData;
  logic [3:0]  ReqBE;
  logic        RspValid = 1'b0, RspErr = 1'b0;
  logic [31:0] RspData = '0;

  int checks = 0;
  int errors = 0;

  // {write, addr, wdata, be}
  logic [68:0] bus_q[$];

  dmem_port #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ByteM(ByteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .DataAbortM(DataAbortM),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqBE(ReqBE),
    .RspValid(RspValid), .RspData(RspData), .RspErr(RspErr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed hang expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus scoreboard: every handshake must match the oldest expected request.
  always @(negedge clk) begin
    if (reset === 1'b1 && ReqValid === 1'b1 && ReqReady === 1'b1) begin
      chk("bus_expected_pending", 69'(bus_q.size() != 0), 69'd1);
      if (bus_q.size() != 0)
        chk("bus_req", {ReqWrite, ReqAddr, ReqWData, ReqBE}, bus_q.pop_front());
    end
  end

  function automatic logic [31:0] load_model(input logic [31:0] addr, input logic b,
                                             input logic [31:0] rsp);
    logic [7:0] sel;
    if (!b) return rsp;
    case (addr[1:0])
      2'd0: sel = rsp[7:0];
      2'd1: sel = rsp[15:8];
      2'd2: sel = rsp[23:16];
      default: sel = rsp[31:24];
    endcase
    return {24'h0, sel};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic b, input logic [31:0] rsp,
                         input logic err, input logic respond, input int ready_delay,
                         input int exp_stalls);
    logic [31:0] exp_rd;
    logic acc;
    int stalls, aborts;
    bit done;
    exp_rd = (respond && !err) ? load_model(addr, b, rsp) : 32'h0;
    bus_q.push_back({1'b0, addr[31:2], 2'b00, 32'h0, 4'hF});
    stalls = 0; aborts = 0; done = 0;
    MemReadM = 1'b1; ALUOutM = addr; ByteM = b;
    for (int i = 0; i < 60; i++) begin
      ReqReady = (i >= ready_delay);
      @(negedge clk);
      if (DataAbortM) aborts++;
      if (!StallM) begin
        done = 1;
        chk("ld_rdata", ReadDataM, exp_rd);
        break;
      end
      stalls++;
      acc = ReqValid && ReqReady && !ReqWrite;
      cyc();
      RspValid = acc && respond;
      RspData = rsp;
      RspErr = err;
    end
    chk("ld_completed", 69'(done), 69'd1);
    chk("ld_stall_cycles", 69'(stalls), 69'(exp_stalls));
    cyc();
    MemReadM = 1'b0; MemWriteM = 1'b0; RspValid = 1'b0; RspErr = 1'b0; ReqReady = 1'b0;
    @(negedge clk);
    if (DataAbortM) aborts++;
    chk("ld_rdata_hold", ReadDataM, exp_rd);
    chk("ld_abort_pulses", 69'(aborts), 69'((respond && !err) ? 0 : 1));
    cyc();
  endtask

  task automatic do_store(input logic [31:0] addr, input logic b, input logic [31:0] data,
                          input int nready);
    logic [31:0] ew;
    logic [3:0]  ebe;
    ew  = b ? {4{data[7:0]}} : data;
    ebe = b ? (4'b0001 << addr[1:0]) : 4'hF;
    bus_q.push_back({1'b1, addr[31:2], 2'b00, ew, ebe});
    MemWriteM = 1'b1; ALUOutM = addr; ByteM = b; WriteDataM = data; ReqReady = 1'b0;
    @(negedge clk);
    chk("st_posted_nostall", StallM, 1'b0);
    cyc();
    MemWriteM = 1'b0; ALUOutM = ~addr; WriteDataM = ~data;
    for (int i = 0; i < nready; i++) begin
      @(negedge clk);
      chk("st_payload_hold", {ReqValid, ReqWrite, ReqAddr, ReqWData, ReqBE},
          {1'b1, 1'b1, addr[31:2], 2'b00, ew, ebe});
      cyc();
    end
    ReqReady = 1'b1;
    cyc();
    ReqReady = 1'b0;
    @(negedge clk);
    chk("st_buffer_empty", ReqValid, 1'b0);
    cyc();
  endtask

  initial begin
    #1 reset = 1'b0;
    #3;
    chk("reset_outputs", {ReadDataM, StallM, DataAbortM, ReqValid, ReqWrite, ReqBE},
        {32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    chk("reset_req_payload", {ReqAddr, ReqWData}, 64'h0);
    @(posedge clk); #1 reset = 1'b1;
    cyc();

    // Word load, minimum latency
    do_load(32'h104, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 0, 3);
    // Byte load, lane 3
    do_load(32'h107, 1'b1, 32'h11223344, 1'b0, 1'b1, 0, 3);
    // Byte store with a slow bus
    do_store(32'h202, 1'b1, 32'h000000AB, 3);
    // Word store, immediate handshake
    do_store(32'h2F0, 1'b0, 32'h5A5AC3C3, 0);

    // Store then immediate load: load waits for the store to drain
    bus_q.push_back({1'b1, 32'h300, 32'h12345678, 4'hF});
    MemWriteM = 1'b1; ALUOutM = 32'h300; WriteDataM = 32'h12345678; ByteM = 1'b0; ReqReady = 1'b0;
    @(negedge clk);
    chk("st_ld_store_nostall", StallM, 1'b0);
    cyc();
    MemWriteM = 1'b0;
    do_load(32'h308, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 2, 6);

    // Store into a full buffer: stall, then capture on the drain cycle
    bus_q.push_back({1'b1, 32'h400, 32'h11111111, 4'hF});
    bus_q.push_back({1'b1, 32'h404, 32'h22222222, 4'hF});
    MemWriteM = 1'b1; ALUOutM = 32'h400; WriteDataM = 32'h11111111; ReqReady = 1'b0;
    @(negedge clk);
    chk("full_first_nostall", StallM, 1'b0);
    cyc();
    ALUOutM = 32'h404; WriteDataM = 32'h22222222;
    @(negedge clk);
    chk("full_second_stall", StallM, 1'b1);
    cyc();
    ReqReady = 1'b1;
    @(negedge clk);
    chk("full_drain_cycle_nostall", StallM, 1'b0);
    cyc();
    MemWriteM = 1'b0;
    @(negedge clk);
    chk("full_second_pending", {ReqValid, ReqWrite, ReqAddr}, {1'b1, 1'b1, 32'h404});
    cyc();
    ReqReady = 1'b0;
    @(negedge clk);
    chk("full_empty", ReqValid, 1'b0);
    cyc();

    // Load and store together: store is dropped
    MemWriteM = 1'b1; WriteDataM = 32'h77777777;
    do_load(32'h500, 1'b0, 32'h01020304, 1'b0, 1'b1, 0, 3);
    @(negedge clk);
    chk("dropped_store", ReqValid, 1'b0);
    cyc();

    // Error response
    do_load(32'h600, 1'b0, 32'h12345678, 1'b1, 1'b1, 0, 3);
    // Timeout: no response, 8 cycles in LD_WAIT
    do_load(32'h700, 1'b0, 32'h0, 1'b0, 1'b0, 0, 10);
    @(negedge clk);
    chk("timeout_back_idle", {StallM, ReqValid, DataAbortM}, 3'b000);
    cyc();
    // Byte load, lane 0
    do_load(32'h800, 1'b1, 32'hA5B6C7D8, 1'b0, 1'b1, 0, 3);

    // Stray response outside LD_WAIT is ignored
    RspValid = 1'b1; RspData = 32'hBADBADBA;
    cyc();
    RspValid = 1'b0;
    @(negedge clk);
    chk("stray_rsp_ignored", {ReadDataM, DataAbortM}, {32'h000000D8, 1'b0});
    cyc();

    // Reset during LD_WAIT, late response afterwards
    bus_q.push_back({1'b0, 32'h900, 32'h0, 4'hF});
    MemReadM = 1'b1; ALUOutM = 32'h900; ByteM = 1'b0; ReqReady = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_ldwait_stall", StallM, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("rst_async_outputs", {ReadDataM, StallM, DataAbortM, ReqValid, ReqWrite, ReqBE},
        {32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    MemReadM = 1'b0; ReqReady = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    RspValid = 1'b1; RspData = 32'hFFFFFFFF;
    cyc();
    RspValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_late_rsp_ignored", {ReadDataM, StallM, DataAbortM, ReqValid},
          {32'h0, 1'b0, 1'b0, 1'b0});
      cyc();
    end

    chk("bus_queue_drained", 69'(bus_q.size()), 69'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
